// File: rtl/jtcop_pkg.sv
// Shared definitions for the DEC0 object RAM port controller: state encoding
// and the default object RAM address width.
package jtcop_pkg;

  localparam int OBJ_AW = 10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CPU_ACC  = 3'd1;
  localparam state_t ST_CPU_HOLD = 3'd2;
  localparam state_t ST_DMA_RD   = 3'd3;
  localparam state_t ST_DMA_WR   = 3'd4;

endpackage

// File: rtl/jtcop_objdma.sv
// Object RAM port controller: arbitrates the single-port object RAM between
// CPU bus cycles and the per-frame DMA copy into the line-buffer source RAM.
module jtcop_objdma
  import jtcop_pkg::*;
#(
  parameter int AW = OBJ_AW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          dma_start,
  input  logic          cpu_cs,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rnw,
  input  logic [1:0]    cpu_dsn,
  input  logic [15:0]   cpu_dout,
  output logic [15:0]   cpu_din,
  output logic          cpu_ok,
  output logic [AW-1:0] ram_addr,
  output logic [1:0]    ram_we,
  output logic [15:0]   ram_din,
  input  logic [15:0]   ram_dout,
  output logic [AW-1:0] buf_addr,
  output logic          buf_we,
  output logic [15:0]   buf_din,
  output logic          busy
);

  state_t        state, state_next;
  logic [AW-1:0] cnt, cnt_next;
  logic          pending, pending_next;
  logic          in_copy, in_copy_next;
  logic [15:0]   din_hold, din_hold_next;
  logic [AW-1:0] ram_addr_next, buf_addr_next;
  logic [1:0]    ram_we_next;
  logic [15:0]   ram_din_next;
  logic          buf_we_next, cpu_ok_next;
  logic          last_word;

  assign last_word = &cnt;
  assign busy      = pending | (state == ST_DMA_RD) | (state == ST_DMA_WR);
  // The RAM word for the CPU arrives on the first hold cycle; show it at once.
  assign cpu_din   = (state == ST_CPU_HOLD) ? ram_dout : din_hold;
  assign buf_din   = buf_we ? ram_dout : 16'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      in_copy  <= 1'b0;
      din_hold <= 16'd0;
      ram_addr <= '0;
      ram_we   <= 2'b00;
      ram_din  <= 16'd0;
      buf_addr <= '0;
      buf_we   <= 1'b0;
      cpu_ok   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      pending  <= pending_next;
      in_copy  <= in_copy_next;
      din_hold <= din_hold_next;
      ram_addr <= ram_addr_next;
      ram_we   <= ram_we_next;
      ram_din  <= ram_din_next;
      buf_addr <= buf_addr_next;
      buf_we   <= buf_we_next;
      cpu_ok   <= cpu_ok_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cpu_cs)       state_next = ST_CPU_ACC;
        else if (pending) state_next = ST_DMA_RD;
      end
      ST_CPU_ACC:  state_next = ST_CPU_HOLD;
      ST_CPU_HOLD: begin
        if (!cpu_cs) state_next = in_copy ? ST_DMA_RD : ST_IDLE;
      end
      ST_DMA_RD:   state_next = ST_DMA_WR;
      ST_DMA_WR: begin
        // A CPU grant always returns to DMA_RD, so granting here whenever the
        // CPU asks yields strict word-by-word alternation.
        if (last_word)   state_next = ST_IDLE;
        else if (cpu_cs) state_next = ST_CPU_ACC;
        else             state_next = ST_DMA_RD;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_next      = cnt;
    pending_next  = pending;
    in_copy_next  = in_copy;
    din_hold_next = (state == ST_CPU_HOLD) ? ram_dout : din_hold;
    ram_addr_next = ram_addr;
    ram_din_next  = ram_din;
    buf_addr_next = buf_addr;
    ram_we_next   = 2'b00;
    buf_we_next   = 1'b0;
    cpu_ok_next   = (state_next == ST_CPU_HOLD);

    if (dma_start && !busy) pending_next = 1'b1;
    if (state == ST_IDLE && state_next == ST_DMA_RD) in_copy_next = 1'b1;
    if (state == ST_DMA_WR) begin
      cnt_next = cnt + AW'(1);
      if (last_word) begin
        pending_next = 1'b0;
        in_copy_next = 1'b0;
      end
    end

    case (state_next)
      ST_CPU_ACC: begin
        ram_addr_next = cpu_addr;
        if (!cpu_rnw) begin
          ram_we_next  = ~cpu_dsn;
          ram_din_next = cpu_dout;
        end
      end
      ST_DMA_RD: ram_addr_next = cnt_next;
      ST_DMA_WR: begin
        buf_we_next   = 1'b1;
        buf_addr_next = cnt;
      end
      default: ;
    endcase
  end

endmodule
